// File: rtl/paint_pkg.sv
// Shared types for the paint sequencer.
// Command bundle, opcodes and FSM states.
package paint_pkg;

  localparam int XMAX_DEF = 640;
  localparam int YMAX_DEF = 480;

  typedef enum logic [1:0] {
    OP_POINT  = 2'b00,
    OP_SQUARE = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  typedef struct packed {
    op_e        op;
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
    logic [1:0] size;
  } paint_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_POINT,
    S_SQUARE,
    S_CLEAR
  } state_e;

endpackage

// File: rtl/cmd_fifo.sv
// Command queue between decoder and walker.
// Head is read combinationally; pop advances it.
module cmd_fifo
  import paint_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  paint_cmd_t din,
  input  logic       pop,
  output paint_cmd_t dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  paint_cmd_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push && !full, pop && !empty})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/paint_sequencer.sv
// Expands queued draw commands into pixel writes.
// wr_x/wr_y are the walker position registers.
module paint_sequencer
  import paint_pkg::*;
#(
  parameter int XMAX        = XMAX_DEF,
  parameter int YMAX        = YMAX_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int WR_IN_BLANK = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [9:0] cmd_x,
  input  logic [9:0] cmd_y,
  input  logic [2:0] cmd_color,
  input  logic [1:0] cmd_size,
  input  logic       blank,
  output logic       wr_en,
  output logic [9:0] wr_x,
  output logic [9:0] wr_y,
  output logic [2:0] wr_color,
  output logic       busy
);

  localparam logic signed [11:0] XL = 12'(XMAX - 1);
  localparam logic signed [11:0] YL = 12'(YMAX - 1);

  state_e     state, state_n;
  paint_cmd_t in_cmd, head;
  logic       full, empty, pop;
  logic       load, step, active, permit, last;
  logic [9:0] x_lo, x_hi, y_hi;

  logic [1:0]        sz;
  logic signed [11:0] xa, xb, ya, yb;
  logic [9:0]        bx0, bx1, by0, by1;
  logic              box_empty;

  assign in_cmd = '{op: op_e'(cmd_op), x: cmd_x, y: cmd_y,
                    color: cmd_color, size: cmd_size};

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (cmd_valid && cmd_ready),
    .din     (in_cmd),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty)
  );

  assign cmd_ready = !full;
  assign busy      = !empty || (state != S_IDLE);
  assign permit    = (WR_IN_BLANK != 0) ? blank : 1'b1;
  assign active    = (state == S_POINT) || (state == S_SQUARE) ||
                     (state == S_CLEAR);
  assign wr_en     = active && permit;
  assign last      = (wr_x == x_hi) && (wr_y == y_hi);

  // Clipped bounding box of the head command; a point is a 0-size box.
  always_comb begin
    sz = (head.op == OP_SQUARE) ? head.size : 2'd0;
    xa = $signed({2'b00, head.x}) - $signed({10'd0, sz});
    xb = $signed({2'b00, head.x}) + $signed({10'd0, sz});
    ya = $signed({2'b00, head.y}) - $signed({10'd0, sz});
    yb = $signed({2'b00, head.y}) + $signed({10'd0, sz});
    bx0 = (xa < 0) ? 10'd0 : xa[9:0];
    by0 = (ya < 0) ? 10'd0 : ya[9:0];
    bx1 = (xb > XL) ? XL[9:0] : xb[9:0];
    by1 = (yb > YL) ? YL[9:0] : yb[9:0];
    box_empty = (xa > XL) || (ya > YL);
    if (head.op == OP_CLEAR) begin
      bx0 = '0;
      by0 = '0;
      bx1 = XL[9:0];
      by1 = YL[9:0];
      box_empty = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state, pop and walker control.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE: if (!empty) state_n = S_LOAD;
      S_LOAD: begin
        pop  = 1'b1;
        load = 1'b1;
        unique case (head.op)
          OP_POINT:  state_n = box_empty ? S_IDLE : S_POINT;
          OP_SQUARE: state_n = box_empty ? S_IDLE : S_SQUARE;
          OP_CLEAR:  state_n = S_CLEAR;
          default:   state_n = S_IDLE;
        endcase
      end
      S_POINT, S_SQUARE, S_CLEAR: begin
        if (wr_en) begin
          step = 1'b1;
          if (last) state_n = empty ? S_IDLE : S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Walker: load box corner, then scan row-major.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_x     <= '0;
      wr_y     <= '0;
      wr_color <= '0;
      x_lo     <= '0;
      x_hi     <= '0;
      y_hi     <= '0;
    end else if (load) begin
      wr_x     <= bx0;
      wr_y     <= by0;
      x_lo     <= bx0;
      x_hi     <= bx1;
      y_hi     <= by1;
      wr_color <= head.color;
    end else if (step) begin
      if (wr_x == x_hi) begin
        wr_x <= x_lo;
        wr_y <= wr_y + 10'd1;
      end else begin
        wr_x <= wr_x + 10'd1;
      end
    end
  end

endmodule

// File: tb/tb_paint_sequencer.sv
// Bench for paint_sequencer: scoreboard of expected writes
// plus directed timing checks on a reduced 128x64 screen.
module tb_paint_sequencer;

  localparam int XM = 128;
  localparam int YM = 64;

  logic       clk = 0;
  logic       reset_n = 0;
  logic       valid0 = 0, valid1 = 0;
  logic [1:0] cmd_op = 0;
  logic [9:0] cmd_x = 0, cmd_y = 0;
  logic [2:0] cmd_color = 0;
  logic [1:0] cmd_size = 0;
  logic       blank = 0;

  logic       rdy0, wr_en0, busy0;
  logic [9:0] wr_x0, wr_y0;
  logic [2:0] wr_color0;
  logic       rdy1, wr_en1, busy1;
  logic [9:0] wr_x1, wr_y1;
  logic [2:0] wr_color1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wc0 = 0, wc1 = 0;
  logic [22:0] sb0[$];
  logic [22:0] sb1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  paint_sequencer #(.XMAX(XM), .YMAX(YM), .FIFO_DEPTH(4),
                    .WR_IN_BLANK(0)) u0 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid0),
    .cmd_ready(rdy0), .cmd_op(cmd_op), .cmd_x(cmd_x),
    .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_size(cmd_size),
    .blank(blank), .wr_en(wr_en0), .wr_x(wr_x0), .wr_y(wr_y0),
    .wr_color(wr_color0), .busy(busy0));

  paint_sequencer #(.XMAX(XM), .YMAX(YM), .FIFO_DEPTH(4),
                    .WR_IN_BLANK(1)) u1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(valid1),
    .cmd_ready(rdy1), .cmd_op(cmd_op), .cmd_x(cmd_x),
    .cmd_y(cmd_y), .cmd_color(cmd_color), .cmd_size(cmd_size),
    .blank(blank), .wr_en(wr_en1), .wr_x(wr_x1), .wr_y(wr_y1),
    .wr_color(wr_color1), .busy(busy1));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_add(input int d, input int x, input int y,
                        input int c);
    logic [22:0] v;
    v = {10'(x), 10'(y), 3'(c)};
    if (d != 0) sb1.push_back(v);
    else        sb0.push_back(v);
  endtask

  // Reference expansion of one command into expected writes.
  task automatic expand(input int d, input int op, input int x,
                        input int y, input int c, input int s);
    int sz, x0, x1, y0, y1;
    if (op == 3) return;
    if (op == 2) begin
      x0 = 0; x1 = XM - 1; y0 = 0; y1 = YM - 1;
    end else begin
      sz = (op == 1) ? s : 0;
      x0 = (x - sz < 0) ? 0 : x - sz;
      y0 = (y - sz < 0) ? 0 : y - sz;
      x1 = (x + sz > XM - 1) ? XM - 1 : x + sz;
      y1 = (y + sz > YM - 1) ? YM - 1 : y + sz;
    end
    for (int yy = y0; yy <= y1; yy++)
      for (int xx = x0; xx <= x1; xx++)
        sb_add(d, xx, yy, c);
  endtask

  task automatic push(input int d, input int op, input int x,
                      input int y, input int c, input int s);
    int n = 0;
    @(negedge clk);
    while (!((d != 0) ? rdy1 : rdy0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n < 5000), 1);
    cmd_op = 2'(op); cmd_x = 10'(x); cmd_y = 10'(y);
    cmd_color = 3'(c); cmd_size = 2'(s);
    if (d != 0) valid1 = 1; else valid0 = 1;
    expand(d, op, x, y, c, s);
    @(posedge clk);
    #1;
    valid0 = 0;
    valid1 = 0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (((d != 0) ? busy1 : busy0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 20000), 1);
  endtask

  // Scoreboard monitor, sampled away from the rising edge.
  always @(negedge clk) begin
    logic [22:0] e;
    if (reset_n) begin
      if (wr_en0) begin
        wc0++;
        if (sb0.size() == 0) chk("wr0_extra", 1, 0);
        else begin
          e = sb0.pop_front();
          chk("wr0", {9'd0, wr_x0, wr_y0, wr_color0}, {9'd0, e});
        end
      end
      if (wr_en1) begin
        wc1++;
        chk("wr1_blank", 32'(blank), 1);
        if (sb1.size() == 0) chk("wr1_extra", 1, 0);
        else begin
          e = sb1.pop_front();
          chk("wr1", {9'd0, wr_x1, wr_y1, wr_color1}, {9'd0, e});
        end
      end
    end
  end

  // Blank toggles every three cycles.
  initial begin
    forever begin
      repeat (3) @(posedge clk);
      #2 blank = ~blank;
    end
  end

  initial begin
    int t0, base;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy0), 1);
    chk("rst_wr_en", 32'(wr_en0), 0);
    chk("rst_wr_x", 32'(wr_x0), 0);
    chk("rst_wr_y", 32'(wr_y0), 0);
    chk("rst_color", 32'(wr_color0), 0);
    chk("rst_busy", 32'(busy0), 0);
    reset_n = 1;

    // Single point: write two cycles after accept.
    push(0, 0, 100, 50, 5, 0);
    @(negedge clk);
    chk("pt_busy_rise", 32'(busy0), 1);
    chk("pt_wr_n", 32'(wr_en0), 0);
    @(negedge clk);
    chk("pt_wr_n1", 32'(wr_en0), 0);
    @(negedge clk);
    chk("pt_wr_en", 32'(wr_en0), 1);
    chk("pt_x", 32'(wr_x0), 100);
    chk("pt_y", 32'(wr_y0), 50);
    chk("pt_c", 32'(wr_color0), 5);
    @(negedge clk);
    chk("pt_wr_off", 32'(wr_en0), 0);
    chk("pt_busy_fall", 32'(busy0), 0);

    // Clipped squares at both corners.
    base = wc0;
    push(0, 1, 0, 0, 2, 2);
    wait_idle(0);
    chk("sq_corner0", 32'(wc0 - base), 9);
    base = wc0;
    push(0, 1, XM - 1, YM - 1, 6, 1);
    wait_idle(0);
    chk("sq_corner1", 32'(wc0 - base), 4);

    // Six back-to-back squares: queue fills, one LOAD gap each.
    push(0, 1, 10, 10, 1, 1);
    t0 = cyc;
    for (int i = 1; i < 5; i++) push(0, 1, 10 + 10 * i, 10 + 5 * i, i, 1);
    chk("fifo_full", 32'(rdy0), 0);
    push(0, 1, 70, 40, 7, 1);
    wait_idle(0);
    chk("stream_cycles", 32'(cyc - t0), 61);

    // Blank-gated square on the second instance.
    base = wc1;
    push(1, 1, 20, 20, 4, 1);
    wait_idle(1);
    chk("blank_count", 32'(wc1 - base), 9);

    // Full clear: consecutive writes, last at the far corner.
    base = wc0;
    push(0, 2, 0, 0, 3, 0);
    t0 = cyc;
    wait_idle(0);
    chk("clear_count", 32'(wc0 - base), XM * YM);
    chk("clear_cycles", 32'(cyc - t0), XM * YM + 2);

    // Reserved op and off-screen point produce nothing.
    base = wc0;
    push(0, 3, 5, 5, 1, 0);
    push(0, 0, 700, 10, 2, 0);
    wait_idle(0);
    chk("discard", 32'(wc0 - base), 0);

    // Reset in the middle of a clear.
    base = wc0;
    push(0, 2, 0, 0, 6, 0);
    for (int n = 0; n < 3000 && (wc0 - base) < 1000; n++)
      @(negedge clk);
    chk("clr_progress", 32'((wc0 - base) >= 1000), 1);
    #2 reset_n = 0;
    #1;
    chk("mid_wr_en", 32'(wr_en0), 0);
    chk("mid_busy", 32'(busy0), 0);
    chk("mid_ready", 32'(rdy0), 1);
    sb0.delete();
    @(negedge clk);
    reset_n = 1;
    base = wc0;
    push(0, 0, 5, 6, 2, 0);
    wait_idle(0);
    chk("post_rst_pt", 32'(wc0 - base), 1);

    chk("sb0_left", 32'(sb0.size()), 0);
    chk("sb1_left", 32'(sb1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
